// File: rtl/tile_access_seq_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// tile_access_seq_if -- stream-in, memory-core and stream-out bus bundle. Rev 1.0
//------------------------------------------------------------------------------
interface tile_access_seq_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  // upstream write stream
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  // memory core
  logic          wen_out;
  logic          ren_out;
  logic [DW-1:0] data_out;
  logic [AW-1:0] addr_out;
  logic          core_valid;
  logic [DW-1:0] core_data;
  // downstream read stream
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (
    input  in_valid, in_data, core_valid, core_data, out_ready,
    output in_ready, wen_out, ren_out, data_out, addr_out, out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, core_valid, core_data, out_ready,
    input  in_ready, wen_out, ren_out, data_out, addr_out, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/tile_access_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// tile_access_seq -- writes a tile, then streams it back via a 3-level strided read. Rev 1.0
//------------------------------------------------------------------------------
module tile_access_seq #(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                flush,
  input  logic [15:0]         cfg_depth,
  input  logic [AW-1:0]       cfg_start_addr,
  input  logic [15:0]         cfg_stride_0,
  input  logic [15:0]         cfg_stride_1,
  input  logic [15:0]         cfg_stride_2,
  input  logic [15:0]         cfg_range_0,
  input  logic [15:0]         cfg_range_1,
  input  logic [15:0]         cfg_range_2,
  tile_access_seq_if.master   bus,
  output logic                tile_done,
  output logic                cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   wr_cnt_q, wr_cnt_d;
  logic [15:0]   i0_q, i1_q, i2_q;
  logic [15:0]   i0_d, i1_d, i2_d;
  logic [AW-1:0] off0_q, off1_q, off2_q;
  logic [AW-1:0] off0_d, off1_d, off2_d;
  logic [47:0]   issue_cnt_q, issue_cnt_d;
  logic          inflight_q, inflight_d;

  logic [DW-1:0] fifo_q [2];
  logic          rd_ptr_q, wr_ptr_q;
  logic [1:0]    cnt_q;

  logic          active;
  logic [15:0]   r0_w, r1_w, r2_w;
  logic [AW-1:0] s0_w, s1_w, s2_w;
  logic [47:0]   total_w;
  logic          all_issued;
  logic [AW-1:0] rd_addr;
  logic          fifo_full, fifo_empty;
  logic          wen, ren, push, pop, done, in_rdy;

  // flush behaves like an enable-independent abort, so it also masks all activity
  assign active     = clk_en & ~flush;
  assign r0_w       = (cfg_range_0 == 16'd0) ? 16'd1 : cfg_range_0;
  assign r1_w       = (cfg_range_1 == 16'd0) ? 16'd1 : cfg_range_1;
  assign r2_w       = (cfg_range_2 == 16'd0) ? 16'd1 : cfg_range_2;
  assign s0_w       = AW'(cfg_stride_0);
  assign s1_w       = AW'(cfg_stride_1);
  assign s2_w       = AW'(cfg_stride_2);
  assign total_w    = {32'd0, r0_w} * {32'd0, r1_w} * {32'd0, r2_w};
  assign all_issued = (issue_cnt_q == total_w);
  assign rd_addr    = cfg_start_addr + off0_q + off1_q + off2_q;
  assign fifo_full  = (cnt_q == 2'd2);
  assign fifo_empty = (cnt_q == 2'd0);

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    i0_d        = i0_q;
    i1_d        = i1_q;
    i2_d        = i2_q;
    off0_d      = off0_q;
    off1_d      = off1_q;
    off2_d      = off2_q;
    issue_cnt_d = issue_cnt_q;
    inflight_d  = inflight_q;
    wen         = 1'b0;
    ren         = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    done        = 1'b0;
    in_rdy      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (active && cfg_depth != 16'd0) state_d = ST_WRITE;
      end

      ST_WRITE: begin
        in_rdy = active;
        if (active && bus.in_valid) begin
          wen      = 1'b1;
          wr_cnt_d = wr_cnt_q + 16'd1;
          if (wr_cnt_q == cfg_depth - 16'd1) begin
            state_d  = ST_READ;
            wr_cnt_d = 16'd0;
          end
        end
      end

      ST_READ: begin
        if (active) begin
          // one-cycle read latency: reserve a FIFO slot for every read in flight
          ren        = ~all_issued && (({1'b0, inflight_q} + cnt_q) < 2'd2);
          inflight_d = ren;
          push       = bus.core_valid & ~fifo_full;
          pop        = ~fifo_empty & bus.out_ready;

          if (ren) begin
            issue_cnt_d = issue_cnt_q + 48'd1;
            if (i0_q == r0_w - 16'd1) begin
              i0_d   = 16'd0;
              off0_d = '0;
              if (i1_q == r1_w - 16'd1) begin
                i1_d   = 16'd0;
                off1_d = '0;
                if (i2_q == r2_w - 16'd1) begin
                  i2_d   = 16'd0;
                  off2_d = '0;
                end else begin
                  i2_d   = i2_q + 16'd1;
                  off2_d = off2_q + s2_w;
                end
              end else begin
                i1_d   = i1_q + 16'd1;
                off1_d = off1_q + s1_w;
              end
            end else begin
              i0_d   = i0_q + 16'd1;
              off0_d = off0_q + s0_w;
            end
          end

          if (all_issued && !inflight_q && !push &&
              (fifo_empty || (cnt_q == 2'd1 && pop))) begin
            state_d     = ST_WRITE;
            done        = pop;
            issue_cnt_d = '0;
            i0_d        = 16'd0;
            i1_d        = 16'd0;
            i2_d        = 16'd0;
            off0_d      = '0;
            off1_d      = '0;
            off2_d      = '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_cnt_q    <= 16'd0;
      i0_q        <= 16'd0;
      i1_q        <= 16'd0;
      i2_q        <= 16'd0;
      off0_q      <= '0;
      off1_q      <= '0;
      off2_q      <= '0;
      issue_cnt_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      i0_q        <= i0_d;
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      off0_q      <= off0_d;
      off1_q      <= off1_d;
      off2_q      <= off2_d;
      issue_cnt_q <= issue_cnt_d;
      inflight_q  <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= bus.core_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // a return into a full FIFO means the issue throttle was bypassed; it is dropped
  always_ff @(posedge clk) begin
    if (reset && active && state_q == ST_READ && bus.core_valid) begin
      assert (!fifo_full);
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.wen_out   = wen;
  assign bus.ren_out   = ren;
  assign bus.data_out  = wen ? bus.in_data : '0;
  assign bus.addr_out  = wen ? AW'(wr_cnt_q) : (ren ? rd_addr : '0);
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : fifo_q[rd_ptr_q];
  assign tile_done     = done;
  assign cfg_err       = (state_q == ST_IDLE) && (cfg_depth == 16'd0);

endmodule
`default_nettype wire

// File: tb/tb_tile_access_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_tile_access_seq -- directed bench for tile_access_seq. Rev 1.0
//------------------------------------------------------------------------------
module tb_tile_access_seq;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        flush;
  logic [15:0] cfg_depth;
  logic [15:0] cfg_start_addr;
  logic [15:0] cfg_stride_0, cfg_stride_1, cfg_stride_2;
  logic [15:0] cfg_range_0, cfg_range_1, cfg_range_2;
  logic        tile_done;
  logic        cfg_err;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_addr [64];

  tile_access_seq_if #(.DW(16), .AW(16)) bus ();

  tile_access_seq #(.DW(16), .AW(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_en         (clk_en),
    .flush          (flush),
    .cfg_depth      (cfg_depth),
    .cfg_start_addr (cfg_start_addr),
    .cfg_stride_0   (cfg_stride_0),
    .cfg_stride_1   (cfg_stride_1),
    .cfg_stride_2   (cfg_stride_2),
    .cfg_range_0    (cfg_range_0),
    .cfg_range_1    (cfg_range_1),
    .cfg_range_2    (cfg_range_2),
    .bus            (bus),
    .tile_done      (tile_done),
    .cfg_err        (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; the memory-core model answers a read one cycle later with addr^A5A5
  task automatic tick();
    logic        r;
    logic [15:0] a;
    r = (bus.ren_out === 1'b1);
    a = bus.addr_out;
    @(posedge clk);
    #1;
    bus.core_valid = r;
    bus.core_data  = r ? (a ^ 16'hA5A5) : 16'h0000;
    #1;
  endtask

  task automatic do_writes(input int n, input logic [15:0] base, input int a0);
    for (int k = 0; k < n; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = base + 16'(k);
      #1;
      chk("wr_ready", 32'(bus.in_ready), 32'd1);
      chk("wr_wen",   32'(bus.wen_out),  32'd1);
      chk("wr_addr",  32'(bus.addr_out), 32'(a0 + k));
      chk("wr_data",  32'(bus.data_out), 32'(base + 16'(k)));
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_read(input int n, input int stall_at);
    int issued, popped, done_cnt, stall_cyc;
    bit fin;
    issued = 0; popped = 0; done_cnt = 0; stall_cyc = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (popped >= stall_at && stall_cyc < 10) begin
        bus.out_ready = 1'b0;
        stall_cyc++;
      end else begin
        bus.out_ready = 1'b1;
      end
      #1;
      if (bus.wen_out && bus.ren_out) chk("strobe_excl", 32'd1, 32'd0);
      if (bus.ren_out) begin
        if (issued < n) chk("rd_addr", 32'(bus.addr_out), 32'(exp_addr[issued]));
        else            chk("rd_extra", 32'(issued), 32'(n - 1));
        issued++;
      end
      if (!bus.out_ready && stall_cyc > 4) begin
        chk("stall_ren",  32'(bus.ren_out),   32'd0);
        chk("stall_full", 32'(bus.out_valid), 32'd1);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("rd_data", 32'(bus.out_data), 32'(exp_addr[popped % 64] ^ 16'hA5A5));
        popped++;
      end
      chk("outstanding_le2", 32'(issued - popped <= 2), 32'd1);
      if (tile_done) begin
        done_cnt++;
        chk("done_at_last_pop", 32'(popped), 32'(n));
        fin = 1'b1;
      end
      tick();
    end
    bus.out_ready = 1'b1;
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("issue_count", 32'(issued), 32'(n));
    #1;
    chk("back_to_write", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b0; clk_en = 1'b1; flush = 1'b0;
    cfg_depth = 16'd0; cfg_start_addr = 16'd0;
    cfg_stride_0 = 16'd0; cfg_stride_1 = 16'd0; cfg_stride_2 = 16'd0;
    cfg_range_0 = 16'd0; cfg_range_1 = 16'd0; cfg_range_2 = 16'd0;
    bus.in_valid = 1'b0; bus.in_data = 16'h0;
    bus.core_valid = 1'b0; bus.core_data = 16'h0;
    bus.out_ready = 1'b1;

    // reset state
    tick(); tick();
    #1;
    chk("rst_strobes", 32'({bus.in_ready, bus.wen_out, bus.ren_out, bus.out_valid, tile_done}), 32'd0);
    chk("rst_addr",    32'(bus.addr_out), 32'd0);
    chk("rst_data",    32'(bus.data_out), 32'd0);
    chk("rst_outdata", 32'(bus.out_data), 32'd0);

    // depth 0: stays idle, cfg_err high, input ignored
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 16'h1234;
    tick(); tick(); tick();
    #1;
    chk("d0_ready",  32'(bus.in_ready), 32'd0);
    chk("d0_wen",    32'(bus.wen_out),  32'd0);
    chk("d0_cfgerr", 32'(cfg_err),      32'd1);
    bus.in_valid = 1'b0;

    // basic tile: depth 4, ranges 2/2/1, strides 1/2/0
    cfg_depth = 16'd4;
    cfg_range_0 = 16'd2; cfg_range_1 = 16'd2; cfg_range_2 = 16'd1;
    cfg_stride_0 = 16'd1; cfg_stride_1 = 16'd2; cfg_stride_2 = 16'd0;
    #1;
    chk("cfgerr_clear", 32'(cfg_err), 32'd0);
    tick();
    do_writes(2, 16'h1000, 0);
    clk_en = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'hDEAD;
    #1;
    chk("ce0_wen",   32'(bus.wen_out),  32'd0);
    chk("ce0_ready", 32'(bus.in_ready), 32'd0);
    tick();
    clk_en = 1'b1;
    do_writes(2, 16'h1002, 2);
    exp_addr[0] = 16'd0; exp_addr[1] = 16'd1; exp_addr[2] = 16'd2; exp_addr[3] = 16'd3;
    run_read(4, 1000);

    // 3x3x3 pattern covering addresses 0..26
    flush = 1'b1;
    #1;
    tick();
    flush = 1'b0;
    cfg_depth = 16'd3;
    cfg_range_0 = 16'd3; cfg_range_1 = 16'd3; cfg_range_2 = 16'd3;
    cfg_stride_0 = 16'd1; cfg_stride_1 = 16'd3; cfg_stride_2 = 16'd9;
    for (int k = 0; k < 27; k++) exp_addr[k] = 16'(k);
    #1;
    tick();
    do_writes(3, 16'h2000, 0);
    run_read(27, 1000);

    // same pattern with a 10-cycle downstream stall
    do_writes(3, 16'h2100, 0);
    run_read(27, 5);

    // address wrap, ranges 1/2 given as 0, depth 1
    flush = 1'b1;
    #1;
    tick();
    flush = 1'b0;
    cfg_depth = 16'd1;
    cfg_start_addr = 16'hFFFE;
    cfg_range_0 = 16'd4; cfg_range_1 = 16'd0; cfg_range_2 = 16'd0;
    cfg_stride_0 = 16'd1; cfg_stride_1 = 16'd7; cfg_stride_2 = 16'd9;
    exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0001;
    #1;
    tick();
    do_writes(1, 16'h3000, 0);
    run_read(4, 1000);

    // flush mid-READ
    do_writes(1, 16'h3100, 0);
    #1;
    chk("fl_ren", 32'(bus.ren_out), 32'd1);
    tick();
    flush = 1'b1;
    #1;
    tick();
    flush = 1'b0;
    #1;
    chk("fl_after", 32'({bus.wen_out, bus.ren_out, bus.out_valid, bus.in_ready, tile_done}), 32'd0);
    tick();

    // reset mid-READ, asserted together with flush and clk_en low
    do_writes(1, 16'h3200, 0);
    #1;
    chk("rs_ren", 32'(bus.ren_out), 32'd1);
    tick();
    reset = 1'b0; flush = 1'b1; clk_en = 1'b0;
    #1;
    tick();
    reset = 1'b1; flush = 1'b0; clk_en = 1'b1;
    #1;
    chk("rs_after", 32'({bus.wen_out, bus.ren_out, bus.out_valid, bus.in_ready, tile_done}), 32'd0);
    tick();
    do_writes(1, 16'h3300, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
